branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/dispatch_pkg.sv | 13 +
 rtl/sat_counter.sv | 33 +++
 rtl/branch_resolver.sv | 137 +++++++++++++
 tb/tb_branch_resolver.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Definitions shared by the dispatch staller and the branch resolver.
package dispatch_pkg;

    localparam int unsigned DefaultTagW = 5;

    typedef enum logic [1:0] {
        StIdle,
        StWaitBr,
        StWaitJalr,
        StRedirect
    } br_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. A clear restarts the count; if enable is also high,
// the restarting cycle is counted as the first one.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d, base;

    always_comb begin
        base    = clr ? '0 : count_q;
        count_d = base;
        if (en && (base != {CNT_W{1'b1}})) begin
            count_d = base + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_resolver.sv
// Tracks one outstanding branch/JALR, waits for its CDB result and issues a
// fetch redirect with IFQ flush when control flow changes.
module branch_resolver
    import dispatch_pkg::*;
#(
    parameter int unsigned TAG_W = DefaultTagW,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             disp_valid,
    input  logic             disp_branch,
    input  logic             disp_jalr,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic             br_cdb_valid,
    input  logic [TAG_W-1:0] br_cdb_tag,
    input  logic             br_cdb_taken,
    input  logic [31:0]      br_cdb_target,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             ifq_flush,
    output logic             branch_solved,
    output logic             jalr_solved,
    output logic [CNT_W-1:0] stall_cycles
);

    br_state_e        state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             is_jalr_q, is_jalr_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             ifq_flush_q, ifq_flush_d;
    logic             branch_solved_q, branch_solved_d;
    logic             jalr_solved_q, jalr_solved_d;
    logic             cdb_match, cnt_clr, cnt_en;

    assign cdb_match = br_cdb_valid && (br_cdb_tag == tag_q);

    always_comb begin
        state_d          = state_q;
        tag_d            = tag_q;
        is_jalr_d        = is_jalr_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        ifq_flush_d      = 1'b0;
        branch_solved_d  = 1'b0;
        jalr_solved_d    = 1'b0;
        cnt_clr          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (disp_valid && disp_branch) begin
                    state_d   = StWaitBr;
                    tag_d     = disp_tag;
                    is_jalr_d = 1'b0;
                    cnt_clr   = 1'b1;
                end else if (disp_valid && disp_jalr) begin
                    state_d   = StWaitJalr;
                    tag_d     = disp_tag;
                    is_jalr_d = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            StWaitBr: begin
                if (cdb_match && !br_cdb_taken) begin
                    state_d         = StIdle;
                    branch_solved_d = 1'b1;
                end else if (cdb_match) begin
                    state_d          = StRedirect;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = br_cdb_target;
                    ifq_flush_d      = 1'b1;
                end
            end
            StWaitJalr: begin
                if (cdb_match) begin
                    state_d          = StRedirect;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = br_cdb_target;
                    ifq_flush_d      = 1'b1;
                end
            end
            StRedirect: begin
                if (redirect_ready) begin
                    state_d          = StIdle;
                    redirect_valid_d = 1'b0;
                    branch_solved_d  = !is_jalr_q;
                    jalr_solved_d    = is_jalr_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // The dispatch cycle itself counts as the first stalled cycle.
        cnt_en = cnt_clr || (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            tag_q            <= '0;
            is_jalr_q        <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            ifq_flush_q      <= 1'b0;
            branch_solved_q  <= 1'b0;
            jalr_solved_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            tag_q            <= tag_d;
            is_jalr_q        <= is_jalr_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            ifq_flush_q      <= ifq_flush_d;
            branch_solved_q  <= branch_solved_d;
            jalr_solved_q    <= jalr_solved_d;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .count(stall_cycles)
    );

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign ifq_flush      = ifq_flush_q;
    assign branch_solved  = branch_solved_q;
    assign jalr_solved    = jalr_solved_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Scenario bench for branch_resolver: a 16-bit-counter instance for the main
// checks and a 4-bit-counter instance for saturation.
module tb_branch_resolver;

    logic        clk, rst_n;
    logic        disp_valid, disp_branch, disp_jalr;
    logic [4:0]  disp_tag, br_cdb_tag;
    logic        br_cdb_valid, br_cdb_taken;
    logic [31:0] br_cdb_target;
    logic        redirect_ready;

    logic        a_rv, a_fl, a_bs, a_js;
    logic [31:0] a_pc;
    logic [15:0] a_cnt;
    logic        b_rv, b_fl, b_bs, b_js;
    logic [31:0] b_pc;
    logic [3:0]  b_cnt;

    typedef struct packed {
        logic        rv;
        logic [31:0] pc;
        logic        fl;
        logic        bs;
        logic        js;
        logic [15:0] cnt;
    } out_t;

    out_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    branch_resolver #(.TAG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .disp_valid(disp_valid), .disp_branch(disp_branch),
        .disp_jalr(disp_jalr), .disp_tag(disp_tag), .br_cdb_valid(br_cdb_valid),
        .br_cdb_tag(br_cdb_tag), .br_cdb_taken(br_cdb_taken), .br_cdb_target(br_cdb_target),
        .redirect_ready(redirect_ready), .redirect_valid(a_rv), .redirect_pc(a_pc),
        .ifq_flush(a_fl), .branch_solved(a_bs), .jalr_solved(a_js), .stall_cycles(a_cnt)
    );

    branch_resolver #(.TAG_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .disp_valid(disp_valid), .disp_branch(disp_branch),
        .disp_jalr(disp_jalr), .disp_tag(disp_tag), .br_cdb_valid(br_cdb_valid),
        .br_cdb_tag(br_cdb_tag), .br_cdb_taken(br_cdb_taken), .br_cdb_target(br_cdb_target),
        .redirect_ready(redirect_ready), .redirect_valid(b_rv), .redirect_pc(b_pc),
        .ifq_flush(b_fl), .branch_solved(b_bs), .jalr_solved(b_js), .stall_cycles(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic rv, input logic [31:0] pc, input logic fl,
                                input logic bs, input logic js, input int cnt);
        out_t o;
        o.rv  = rv;
        o.pc  = pc;
        o.fl  = fl;
        o.bs  = bs;
        o.js  = js;
        o.cnt = 16'(cnt);
        return o;
    endfunction

    function automatic out_t observe();
        out_t o;
        o = {a_rv, a_pc, a_fl, a_bs, a_js, a_cnt};
        return o;
    endfunction

    task automatic clear_inputs();
        disp_valid     = 1'b0;
        disp_branch    = 1'b0;
        disp_jalr      = 1'b0;
        disp_tag       = 5'd0;
        br_cdb_valid   = 1'b0;
        br_cdb_tag     = 5'd0;
        br_cdb_taken   = 1'b0;
        br_cdb_target  = 32'h0;
        redirect_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        clear_inputs();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (observe() !== '0) begin
            errors++;
            $display("FAIL reset_main: got %h want 0", observe());
        end
        checks++;
        if ({b_rv, b_pc, b_fl, b_bs, b_js, b_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_sat: got cnt=%0d rv=%b", b_cnt, b_rv);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_not_taken();
        out_t e, got, want;
        for (int c = 0; c < 7; c++) begin
            clear_inputs();
            e = mk(0, 32'h0, 0, (c == 4), 0, (c < 5) ? c + 1 : 5);
            if (c == 0) begin
                disp_valid = 1'b1; disp_branch = 1'b1; disp_tag = 5'd3;
            end
            if (c == 2) begin
                br_cdb_valid = 1'b1; br_cdb_tag = 5'd4; br_cdb_taken = 1'b1;
            end
            if (c == 4) begin
                br_cdb_valid = 1'b1; br_cdb_tag = 5'd3; br_cdb_target = 32'hffff_0000;
            end
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL not_taken c%0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_taken_backpressure();
        out_t e, got, want;
        for (int c = 0; c < 7; c++) begin
            clear_inputs();
            e = mk((c >= 1 && c <= 4), (c >= 1) ? 32'h1040 : 32'h0, (c == 1), (c == 5), 0,
                   (c < 6) ? c + 1 : 6);
            if (c == 0) begin
                disp_valid = 1'b1; disp_branch = 1'b1; disp_tag = 5'd7;
            end
            if (c == 1) begin
                br_cdb_valid = 1'b1; br_cdb_tag = 5'd7; br_cdb_taken = 1'b1;
                br_cdb_target = 32'h0000_1040;
            end
            if (c == 3) begin
                br_cdb_valid = 1'b1; br_cdb_tag = 5'd7; br_cdb_target = 32'h0000_0bad;
            end
            if (c == 5) redirect_ready = 1'b1;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL taken_bp c%0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_jalr();
        out_t e, got, want;
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            redirect_ready = 1'b1;
            e = mk((c == 2), (c >= 2) ? 32'h2000 : 32'h1040, (c == 2), 0, (c == 3),
                   (c < 4) ? c + 1 : 4);
            if (c == 0) begin
                disp_valid = 1'b1; disp_jalr = 1'b1; disp_tag = 5'd2;
            end
            if (c == 1) begin
                br_cdb_valid = 1'b1; br_cdb_tag = 5'd9; br_cdb_taken = 1'b1;
                br_cdb_target = 32'hdead_beef;
            end
            if (c == 2) begin
                br_cdb_valid = 1'b1; br_cdb_tag = 5'd2; br_cdb_target = 32'h0000_2000;
            end
            if (c == 3) begin
                disp_valid = 1'b1; disp_branch = 1'b1; disp_tag = 5'd5;
            end
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL jalr c%0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_priority_ignore();
        out_t e, got, want;
        int   cnt_tab[6] = '{4, 1, 2, 3, 4, 4};
        for (int c = 0; c < 6; c++) begin
            clear_inputs();
            e = mk(0, 32'h2000, 0, (c == 4), 0, cnt_tab[c]);
            if (c == 0) begin
                br_cdb_valid = 1'b1; br_cdb_tag = 5'd2; br_cdb_taken = 1'b1;
                br_cdb_target = 32'h0000_3000;
            end
            if (c == 1) begin
                disp_valid = 1'b1; disp_branch = 1'b1; disp_jalr = 1'b1; disp_tag = 5'd4;
                br_cdb_valid = 1'b1; br_cdb_tag = 5'd4;
            end
            if (c == 2) begin
                disp_valid = 1'b1; disp_branch = 1'b1; disp_tag = 5'd5;
            end
            if (c == 3) begin
                br_cdb_valid = 1'b1; br_cdb_tag = 5'd5;
            end
            if (c == 4) begin
                br_cdb_valid = 1'b1; br_cdb_tag = 5'd4; br_cdb_target = 32'h0000_3000;
            end
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL priority c%0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_t e, got, want;
        int   cnt_tab[6] = '{1, 2, 1, 2, 3, 3};
        for (int c = 0; c < 6; c++) begin
            clear_inputs();
            redirect_ready = 1'b1;
            e = mk((c == 3), (c >= 3) ? 32'h44 : 32'h2000, (c == 3), (c == 1), (c == 4),
                   cnt_tab[c]);
            if (c == 0) begin
                disp_valid = 1'b1; disp_branch = 1'b1; disp_tag = 5'd1;
            end
            if (c == 1) begin
                br_cdb_valid = 1'b1; br_cdb_tag = 5'd1;
            end
            if (c == 2) begin
                disp_valid = 1'b1; disp_jalr = 1'b1; disp_tag = 5'd6;
            end
            if (c == 3) begin
                br_cdb_valid = 1'b1; br_cdb_tag = 5'd6; br_cdb_target = 32'h0000_0044;
            end
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL b2b c%0d: got %h want %h", c, got, want);
            end
        end
    endtask

    task automatic test_saturation_reset();
        out_t got, want;
        int   sat_q[$];
        for (int c = 0; c < 21; c++) begin
            clear_inputs();
            if (c == 0) begin
                disp_valid = 1'b1; disp_branch = 1'b1; disp_tag = 5'd8;
            end
            sat_q.push_back((c + 1 > 15) ? 15 : c + 1);
            @(posedge clk);
            #1;
            checks++;
            if (b_cnt !== 4'(sat_q.pop_front())) begin
                errors++;
                $display("FAIL sat c%0d: got %0d", c, b_cnt);
            end
        end
        checks++;
        if (a_cnt !== 16'd21) begin
            errors++;
            $display("FAIL wide_cnt: got %0d want 21", a_cnt);
        end
        clear_inputs();
        br_cdb_valid = 1'b1; br_cdb_tag = 5'd8; br_cdb_taken = 1'b1;
        br_cdb_target = 32'h0000_5000;
        exp_q.push_back(mk(1, 32'h5000, 1, 0, 0, 22));
        @(posedge clk);
        #1;
        clear_inputs();
        got  = observe();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL sat_redirect: got %h want %h", got, want);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (observe() !== '0) begin
            errors++;
            $display("FAIL mid_reset_main: got %h want 0", observe());
        end
        checks++;
        if ({b_rv, b_pc, b_fl, b_bs, b_js, b_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset_sat: got rv=%b pc=%h cnt=%0d", b_rv, b_pc, b_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            redirect_ready = 1'b1;
            br_cdb_valid = 1'b1; br_cdb_tag = 5'd0; br_cdb_taken = 1'b1;
            exp_q.push_back(mk(0, 32'h0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want || b_bs !== 1'b0 || b_js !== 1'b0 || b_rv !== 1'b0) begin
                errors++;
                $display("FAIL post_reset c%0d: got %h want %h (sat bs=%b js=%b)",
                         c, got, want, b_bs, b_js);
            end
        end
    endtask

    initial begin
        test_reset();
        test_not_taken();
        test_taken_backpressure();
        test_jalr();
        test_priority_ignore();
        test_back_to_back();
        test_saturation_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
